// File: rtl/dma_read_cmd_splitter_if.sv
// axis_mem_cmd: valid/ready memory command bundle (64-bit address,
// 32-bit byte length) shared by the read engine and the DMA core.
interface axis_mem_cmd;
    logic        valid;
    logic        ready;
    logic [63:0] address;
    logic [31:0] length;

    modport master (
        output valid,
        output address,
        output length,
        input  ready
    );

    modport slave (
        input  valid,
        input  address,
        input  length,
        output ready
    );
endinterface

// File: rtl/dma_read_cmd_splitter.sv
// dma_read_cmd_splitter: cuts host-DMA read commands into page-safe,
// size-capped sub-commands and throttles them by in-flight count.
module dma_read_cmd_splitter #(
    parameter int BOUNDARY        = 4096,
    parameter int MAX_CHUNK       = 4096,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic        clk,
    input  logic        rstn,
    axis_mem_cmd.slave  s_axis_cmd,
    axis_mem_cmd.master m_axis_cmd,
    input  logic        rd_data_valid,
    input  logic        rd_data_ready,
    input  logic        rd_data_last,
    output logic [7:0]  outstanding,
    output logic        busy,
    output logic        err_underflow,
    output logic [31:0] cmds_in,
    output logic [31:0] chunks_out,
    output logic [31:0] chunks_done
);
    localparam int OFS_W = $clog2(BOUNDARY);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] cur_addr;
    logic [31:0] rem_len;
    logic [31:0] chunk;
    logic [32:0] page_room;
    logic [32:0] chunk_calc;
    logic        calc_unused;
    logic        s_ready;
    logic        m_valid;
    logic        s_fire;
    logic        m_fire;
    logic        done;
    logic        credit_ok;

    assign credit_ok = outstanding < 8'(MAX_OUTSTANDING);
    assign s_ready   = rstn && (state == IDLE);
    assign m_valid   = rstn && (state == ISSUE) && credit_ok;
    assign s_fire    = s_axis_cmd.valid && s_ready;
    assign m_fire    = m_valid && m_axis_cmd.ready;
    assign done      = rd_data_valid && rd_data_ready && rd_data_last;

    assign s_axis_cmd.ready   = s_ready;
    assign m_axis_cmd.valid   = m_valid;
    assign m_axis_cmd.address = cur_addr;
    assign m_axis_cmd.length  = chunk;

    assign busy = (state != IDLE) || (outstanding != 8'd0);

    // Next chunk: smallest of remaining length, size cap and room left in page.
    always_comb begin
        page_room  = 33'(BOUNDARY) - 33'(cur_addr[OFS_W-1:0]);
        chunk_calc = {1'b0, rem_len};
        if (chunk_calc > 33'(MAX_CHUNK)) chunk_calc = 33'(MAX_CHUNK);
        if (chunk_calc > page_room) chunk_calc = page_room;
    end

    // The result never exceeds MAX_CHUNK, so the top bit is always zero.
    assign calc_unused = chunk_calc[32];

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: accept, size one chunk, issue it, repeat.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (s_fire && (s_axis_cmd.length != 32'd0)) state_nxt = CALC;
            end
            CALC: state_nxt = ISSUE;
            ISSUE: begin
                if (m_fire) state_nxt = (rem_len == chunk) ? IDLE : CALC;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Parent-command datapath and event counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_addr    <= '0;
            rem_len     <= '0;
            chunk       <= '0;
            cmds_in     <= '0;
            chunks_out  <= '0;
            chunks_done <= '0;
        end else begin
            if (s_fire) begin
                cur_addr <= s_axis_cmd.address;
                rem_len  <= s_axis_cmd.length;
                cmds_in  <= cmds_in + 32'd1;
            end
            if (state == CALC) chunk <= chunk_calc[31:0];
            if (m_fire) begin
                cur_addr   <= cur_addr + {32'd0, chunk};
                rem_len    <= rem_len - chunk;
                chunks_out <= chunks_out + 32'd1;
            end
            if (done) chunks_done <= chunks_done + 32'd1;
        end
    end

    // In-flight tracking; a retire with nothing in flight is flagged, not wrapped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else if (m_fire && !done) begin
            outstanding <= outstanding + 8'd1;
        end else if (done && !m_fire) begin
            if (outstanding == 8'd0) err_underflow <= 1'b1;
            else                     outstanding   <= outstanding - 8'd1;
        end
    end
endmodule

// File: doc/dma_read_cmd_splitter.md
# dma_read_cmd_splitter

Splits host-DMA read commands into sub-commands that never cross a BOUNDARY-byte page and are never longer than MAX_CHUNK bytes. It caps the number of in-flight sub-commands by watching the returned read-data stream. It sits between the DMA read engine's command master and the DMA core's read-command slave. It taps, but does not drive, the read-data handshake.

## Interface
- BOUNDARY, 4096: page size in bytes; power of two, ≥ 64.
- MAX_CHUNK, 4096: maximum sub-command length in bytes; power of two, 64 ≤ MAX_CHUNK ≤ BOUNDARY.
- MAX_OUTSTANDING, 16: maximum number of issued sub-commands whose data has not yet completed; 1..255.
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- s_axis_cmd  axis_mem_cmd.slave  valid/ready, address[63:0], length[31:0]: parent command from the read engine.
- m_axis_cmd  axis_mem_cmd.master  valid/ready, address[63:0], length[31:0]: sub-command to the DMA core.
- rd_data_valid, rd_data_ready, rd_data_last  in  1 each: tap of the read-data stream.
- outstanding  out  8  current in-flight sub-command count.
- busy  out  1  high when the FSM is not in IDLE or outstanding ≠ 0.
- err_underflow  out  1  sticky flag; cleared only by reset.
- cmds_in, chunks_out, chunks_done  out  32 each: counters for parent commands accepted, sub-commands issued, and sub-commands completed. All wrap modulo 2^32.

## Operation
- FSM states: IDLE, CALC, ISSUE.
- IDLE:
  - s_axis_cmd.ready = 1.
  - On an s fire: latch cur_addr and rem_len, increment cmds_in.
  - If length ≠ 0, go to CALC. If length = 0, the command is dropped and the FSM stays in IDLE.
- CALC:
  - Register chunk = min(rem_len, MAX_CHUNK, BOUNDARY − (cur_addr mod BOUNDARY)). Compute in 33 bits; the result is never 0.
  - Go to ISSUE.
- ISSUE:
  - m_axis_cmd.valid = (outstanding < MAX_OUTSTANDING).
  - m address = cur_addr, m length = chunk. Both are held stable while valid is high and ready is low.
  - On an m fire: cur_addr += chunk (full 64-bit add), rem_len −= chunk, increment chunks_out.
  - After the fire, go to IDLE if the new rem_len = 0, else go to CALC.
- s_axis_cmd.ready = 0 in CALC and ISSUE. Only one parent command is in flight at a time.
- Completion: a tap cycle with rd_data_valid & rd_data_ready & rd_data_last retires one sub-command and increments chunks_done.
- outstanding update, per cycle:
  - Increment on an m fire.
  - Decrement on a completion.
  - Unchanged when both happen in the same cycle.
  - A completion with outstanding = 0 and no simultaneous m fire leaves outstanding at 0 and sets err_underflow.
- Parent address and length are multiples of 64 in normal use. Unaligned values are passed through arithmetically unchanged.

## Timing
- Reset values: FSM = IDLE; s ready = 0 during the reset cycle and 1 after; m valid = 0; m address and length = 0; outstanding = 0; busy = 0; err_underflow = 0; all counters = 0.
- Latency:
  - s fire in cycle T → m valid earliest in T+2.
  - m fire in cycle U → next sub-command valid earliest in U+2.
  - After the final m fire, s ready returns in U+1.
- outstanding and the counters update on the clock edge after the qualifying event.
- m valid falls in the cycle after outstanding reaches MAX_OUTSTANDING. It re-rises in the cycle after the completion that lowers outstanding.
- m valid never deasserts while in ISSUE unless outstanding has reached MAX_OUTSTANDING.
- Reset mid-operation: the pending parent command and remaining chunks are discarded. outstanding is forced to 0; late completions that follow set err_underflow.

## Test plan
- Page-aligned split: s cmd addr 0x1000, len 0x2000 → m (0x1000, 0x1000) then (0x2000, 0x1000); chunks_out = 2, cmds_in = 1.
- Boundary straddle: addr 0x0FC0, len 0x100 → m (0x0FC0, 0x40) then (0x1000, 0xC0).
- MAX_CHUNK limit with MAX_CHUNK = 512, addr 0x0, len 0x600 → m (0x0, 0x200), (0x200, 0x200), (0x400, 0x200).
- Zero length: s cmd len 0 → accepted, no m valid, cmds_in = 1, s ready stays 1.
- Credit stall with MAX_OUTSTANDING = 2, addr 0, len 0x4000, m ready = 1, no data returned:
  - Two sub-commands issue, then m valid is held low.
  - One last-beat completion → third sub-command issues on the following cycle.
  - An m fire and a last beat in the same cycle → outstanding unchanged.
- Underflow and reset: a last beat at idle with outstanding = 0 → err_underflow = 1, outstanding = 0. Reset asserted mid-split → m valid = 0 and all counters = 0 next cycle; a new command after reset splits correctly.
